// File: rtl/piece_controller.sv
// Active-piece controller: spawns, moves, rotates and drops a piece through an external collision checker.
// Optional hard drop: define PIECE_HARD_DROP_EN to make key_drop fall until it hits, then lock.
module piece_controller (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_rot,
    input  logic       key_drop,
    input  logic [2:0] rnd,
    input  logic       chk_ack,
    input  logic       chk_hit,
    output logic       chk_req,
    output logic [2:0] cand_shape,
    output logic [4:0] cand_left,
    output logic [4:0] cand_top,
    output logic [1:0] cand_rot,
    output logic [2:0] shape,
    output logic [4:0] left,
    output logic [4:0] top,
    output logic [1:0] rotation,
    output logic       alive,
    output logic       lock_pulse,
    output logic       game_over
);

    typedef enum logic [2:0] {IDLE, SPAWN, READY, CHECK, LOCK, OVER} state_t;
    typedef enum logic [2:0] {MV_SPAWN, MV_LEFT, MV_RIGHT, MV_ROT, MV_GRAV, MV_DROP} move_t;

    typedef struct packed {
        logic [2:0] shape;
        logic [4:0] left;
        logic [4:0] top;
        logic [1:0] rot;
    } piece_t;

    state_t state, nxt_state;
    move_t  move, nxt_move;
    piece_t cur, nxt_cur;
    piece_t cand, nxt_cand;
    logic   tick_pending, nxt_tick_pending;
    logic   alive_q, nxt_alive;
    logic   chk_req_q, nxt_chk_req;
    logic   go;
    logic   falling;

    // NOTE: synchronous reset and <= only, so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            move         <= MV_SPAWN;
            cur          <= '0;
            cand         <= '0;
            tick_pending <= 1'b0;
            alive_q      <= 1'b0;
            chk_req_q    <= 1'b0;
        end else begin
            state        <= nxt_state;
            move         <= nxt_move;
            cur          <= nxt_cur;
            cand         <= nxt_cand;
            tick_pending <= nxt_tick_pending;
            alive_q      <= nxt_alive;
            chk_req_q    <= nxt_chk_req;
        end
    end

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        nxt_state        = state;
        nxt_move         = move;
        nxt_cur          = cur;
        nxt_cand         = cand;
        nxt_tick_pending = tick_pending | tick;
        nxt_alive        = alive_q;
        nxt_chk_req      = chk_req_q;
        go               = 1'b0;
        falling          = 1'b0;

        case (state)
            IDLE, OVER: begin
                if (start) nxt_state = SPAWN;
            end

            SPAWN: begin
                nxt_cand.shape = (rnd == 3'd7) ? 3'd0 : rnd;
                nxt_cand.left  = 5'd3;
                nxt_cand.top   = 5'd0;
                nxt_cand.rot   = 2'd0;
                nxt_move       = MV_SPAWN;
                nxt_chk_req    = 1'b1;
                nxt_state      = CHECK;
            end

            READY: begin
                nxt_cand = cur;
                if (key_drop) begin
                    nxt_cand.top = cur.top + 5'd1;
`ifdef PIECE_HARD_DROP_EN
                    nxt_move     = MV_DROP;
`else
                    nxt_move     = MV_GRAV;
`endif
                    go           = 1'b1;
                    falling      = 1'b1;
                end else if (key_rot) begin
                    nxt_cand.rot = cur.rot + 2'd1;
                    nxt_move     = MV_ROT;
                    go           = 1'b1;
                end else if (key_left) begin
                    // Edge moves are dropped here so a wrapped column never reaches the checker.
                    if (cur.left != 5'd0) begin
                        nxt_cand.left = cur.left - 5'd1;
                        nxt_move      = MV_LEFT;
                        go            = 1'b1;
                    end
                end else if (key_right) begin
                    if (cur.left != 5'd31) begin
                        nxt_cand.left = cur.left + 5'd1;
                        nxt_move      = MV_RIGHT;
                        go            = 1'b1;
                    end
                end else if (tick_pending || tick) begin
                    nxt_tick_pending = 1'b0;
                    nxt_cand.top     = cur.top + 5'd1;
                    nxt_move         = MV_GRAV;
                    go               = 1'b1;
                    falling          = 1'b1;
                end

                if (go) begin
                    if (falling && cur.top == 5'd31) begin
                        nxt_state = LOCK;
                        nxt_alive = 1'b0;
                    end else begin
                        nxt_chk_req = 1'b1;
                        nxt_state   = CHECK;
                    end
                end
            end

            CHECK: begin
                if (!chk_req_q) begin
                    nxt_chk_req = 1'b1;
                end else if (chk_ack) begin
                    nxt_chk_req = 1'b0;
                    if (!chk_hit) begin
                        nxt_cur   = cand;
                        nxt_alive = 1'b1;
                        if (move == MV_DROP) begin
                            // Hard drop stays in CHECK; the request re-rises next cycle one row lower.
                            if (cand.top == 5'd31) begin
                                nxt_state = LOCK;
                                nxt_alive = 1'b0;
                            end else begin
                                nxt_cand.top = cand.top + 5'd1;
                            end
                        end else begin
                            nxt_state = READY;
                        end
                    end else begin
                        case (move)
                            MV_SPAWN: begin
                                nxt_state = OVER;
                                nxt_alive = 1'b0;
                            end
                            MV_GRAV, MV_DROP: begin
                                nxt_state = LOCK;
                                nxt_alive = 1'b0;
                            end
                            default: nxt_state = READY;
                        endcase
                    end
                end
            end

            LOCK: nxt_state = SPAWN;

            default: nxt_state = IDLE;
        endcase
    end

    assign chk_req    = chk_req_q;
    assign cand_shape = cand.shape;
    assign cand_left  = cand.left;
    assign cand_top   = cand.top;
    assign cand_rot   = cand.rot;
    assign shape      = cur.shape;
    assign left       = cur.left;
    assign top        = cur.top;
    assign rotation   = cur.rot;
    assign alive      = alive_q;
    assign lock_pulse = (state == LOCK);
    assign game_over  = (state == OVER);

endmodule

// File: tb/tb_piece_controller.sv
// Self-checking bench for piece_controller: directed scenarios plus a randomized run
// against a transaction-level model of the piece rules.
module tb_piece_controller;

    logic       Clk;
    logic       Reset;
    logic       start, tick, key_left, key_right, key_rot, key_drop;
    logic [2:0] rnd;
    logic       chk_ack, chk_hit;
    logic       chk_req;
    logic [2:0] cand_shape;
    logic [4:0] cand_left, cand_top;
    logic [1:0] cand_rot;
    logic [2:0] shape;
    logic [4:0] left, top;
    logic [1:0] rotation;
    logic       alive, lock_pulse, game_over;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0] shape;
        logic [4:0] left;
        logic [4:0] top;
        logic [1:0] rot;
    } piece_t;

    localparam int C_SPAWN = 0;
    localparam int C_SIDE  = 1;
    localparam int C_ROT   = 2;
    localparam int C_GRAV  = 3;
    localparam int C_HDROP = 4;

    piece_controller dut (
        .Clk(Clk), .Reset(Reset), .start(start), .tick(tick),
        .key_left(key_left), .key_right(key_right), .key_rot(key_rot), .key_drop(key_drop),
        .rnd(rnd), .chk_ack(chk_ack), .chk_hit(chk_hit), .chk_req(chk_req),
        .cand_shape(cand_shape), .cand_left(cand_left), .cand_top(cand_top), .cand_rot(cand_rot),
        .shape(shape), .left(left), .top(top), .rotation(rotation),
        .alive(alive), .lock_pulse(lock_pulse), .game_over(game_over)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] committed_bus();
        return {alive, shape, left, top, rotation};
    endfunction

    function automatic logic [15:0] cand_bus();
        return {chk_req, cand_shape, cand_left, cand_top, cand_rot};
    endfunction

    function automatic logic [2:0] shape_of(input logic [2:0] r);
        return (r == 3'd7) ? 3'd0 : r;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; tick = 0; key_left = 0; key_right = 0; key_rot = 0; key_drop = 0;
        chk_ack = 0; chk_hit = 0;
    endtask

    task automatic ack(input bit hit);
        chk_ack = 1; chk_hit = hit;
        step();
        chk_ack = 0; chk_hit = 0;
    endtask

    task automatic test_reset();
        Reset = 1; clear_inputs(); rnd = 3'd0;
        step(); step();
        n_cmp++;
        if ({committed_bus(), cand_bus(), lock_pulse, game_over} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h/%h lock=%b over=%b want all zero",
                     committed_bus(), cand_bus(), lock_pulse, game_over);
        end
        Reset = 0;
        rnd = 3'd2; start = 1; step(); start = 0; step();
        n_cmp++;
        if (chk_req !== 1'b1) begin
            n_bad++; $display("FAIL reset_pre_check: chk_req got %b want 1", chk_req);
        end
        Reset = 1; chk_ack = 1; step();
        Reset = 0; step();
        chk_ack = 0;
        n_cmp++;
        if ({committed_bus(), cand_bus(), game_over} !== 33'd0) begin
            n_bad++;
            $display("FAIL reset_during_check: got %h/%h over=%b want all zero",
                     committed_bus(), cand_bus(), game_over);
        end
        step();
        n_cmp++;
        if (chk_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle_hold: chk_req got %b want 0", chk_req);
        end
    endtask

    task automatic test_spawn();
        rnd = 3'd4; start = 1; step(); start = 0; step();
        n_cmp++;
        if (cand_bus() !== {1'b1, 3'd4, 5'd3, 5'd0, 2'd0}) begin
            n_bad++; $display("FAIL spawn_cand: got %h want %h", cand_bus(), {1'b1, 3'd4, 5'd3, 5'd0, 2'd0});
        end
        ack(0);
        n_cmp++;
        if ({chk_req, committed_bus()} !== {1'b0, 1'b1, 3'd4, 5'd3, 5'd0, 2'd0}) begin
            n_bad++; $display("FAIL spawn_commit: got req=%b %h want req=0 %h",
                              chk_req, committed_bus(), {1'b1, 3'd4, 5'd3, 5'd0, 2'd0});
        end
    endtask

    task automatic test_left_edge();
        for (int k = 2; k >= 0; k--) begin
            key_left = 1; step(); key_left = 0;
            n_cmp++;
            if ({chk_req, cand_left} !== {1'b1, 5'(k)}) begin
                n_bad++; $display("FAIL left_move: got req=%b left=%0d want req=1 left=%0d", chk_req, cand_left, k);
            end
            ack(0);
        end
        key_left = 1; step(); key_left = 0;
        n_cmp++;
        if ({chk_req, left} !== 6'd0) begin
            n_bad++; $display("FAIL left_edge: got req=%b left=%0d want req=0 left=0", chk_req, left);
        end
        step();
        n_cmp++;
        if (chk_req !== 1'b0) begin
            n_bad++; $display("FAIL left_edge_late: chk_req got %b want 0", chk_req);
        end
    endtask

    task automatic test_rot_tick();
        key_rot = 1; tick = 1; step(); key_rot = 0; tick = 0;
        n_cmp++;
        if (cand_bus() !== {1'b1, 3'd4, 5'd0, 5'd0, 2'd1}) begin
            n_bad++; $display("FAIL rot_first: got %h want %h", cand_bus(), {1'b1, 3'd4, 5'd0, 5'd0, 2'd1});
        end
        ack(0);
        step();
        n_cmp++;
        if (cand_bus() !== {1'b1, 3'd4, 5'd0, 5'd1, 2'd1}) begin
            n_bad++; $display("FAIL rot_then_grav: got %h want %h", cand_bus(), {1'b1, 3'd4, 5'd0, 5'd1, 2'd1});
        end
        ack(0);
        step(); step();
        n_cmp++;
        if ({chk_req, top} !== {1'b0, 5'd1}) begin
            n_bad++; $display("FAIL tick_once: got req=%b top=%0d want req=0 top=1", chk_req, top);
        end
    endtask

    task automatic test_lock();
        for (int t = 1; t < 17; t++) begin
            tick = 1; step(); tick = 0;
            n_cmp++;
            if ({chk_req, cand_top} !== {1'b1, 5'(t + 1)}) begin
                n_bad++; $display("FAIL grav_step: got req=%b top=%0d want req=1 top=%0d", chk_req, cand_top, t + 1);
            end
            ack(0);
        end
        tick = 1; step(); tick = 0;
        rnd = 3'd7;
        ack(1);
        n_cmp++;
        if ({lock_pulse, alive, top} !== {1'b1, 1'b0, 5'd17}) begin
            n_bad++; $display("FAIL lock_pulse: got lock=%b alive=%b top=%0d want 1/0/17", lock_pulse, alive, top);
        end
        step();
        n_cmp++;
        if (lock_pulse !== 1'b0) begin
            n_bad++; $display("FAIL lock_width: lock_pulse got %b want 0", lock_pulse);
        end
        step();
        n_cmp++;
        if (cand_bus() !== {1'b1, 3'd0, 5'd3, 5'd0, 2'd0}) begin
            n_bad++; $display("FAIL respawn_rnd7: got %h want %h", cand_bus(), {1'b1, 3'd0, 5'd3, 5'd0, 2'd0});
        end
        ack(0);
    endtask

    task automatic test_game_over();
        rnd = 3'd2;
        tick = 1; step(); tick = 0;
        ack(1);
        step(); step();
        n_cmp++;
        if (cand_bus() !== {1'b1, 3'd2, 5'd3, 5'd0, 2'd0}) begin
            n_bad++; $display("FAIL over_spawn_cand: got %h want %h", cand_bus(), {1'b1, 3'd2, 5'd3, 5'd0, 2'd0});
        end
        ack(1);
        n_cmp++;
        if ({game_over, alive, chk_req} !== 3'b100) begin
            n_bad++; $display("FAIL game_over: got over=%b alive=%b req=%b want 1/0/0", game_over, alive, chk_req);
        end
        key_left = 1; key_rot = 1; step(); key_left = 0; key_rot = 0;
        n_cmp++;
        if ({game_over, chk_req} !== 2'b10) begin
            n_bad++; $display("FAIL over_keys_dropped: got over=%b req=%b want 1/0", game_over, chk_req);
        end
        rnd = 3'd5; start = 1; step(); start = 0;
        n_cmp++;
        if (game_over !== 1'b0) begin
            n_bad++; $display("FAIL over_cleared: game_over got %b want 0", game_over);
        end
        step();
        n_cmp++;
        if (cand_bus() !== {1'b1, 3'd5, 5'd3, 5'd0, 2'd0}) begin
            n_bad++; $display("FAIL restart_cand: got %h want %h", cand_bus(), {1'b1, 3'd5, 5'd3, 5'd0, 2'd0});
        end
        ack(0);
        n_cmp++;
        if (committed_bus() !== {1'b1, 3'd5, 5'd3, 5'd0, 2'd0}) begin
            n_bad++; $display("FAIL restart_commit: got %h want %h", committed_bus(), {1'b1, 3'd5, 5'd3, 5'd0, 2'd0});
        end
    endtask

`ifdef PIECE_HARD_DROP_EN
    task automatic test_drop();
        key_drop = 1; step(); key_drop = 0;
        for (int k = 1; k <= 6; k++) begin
            n_cmp++;
            if (cand_bus() !== {1'b1, 3'd5, 5'd3, 5'(k), 2'd0}) begin
                n_bad++; $display("FAIL hard_drop_req%0d: got %h want %h", k, cand_bus(), {1'b1, 3'd5, 5'd3, 5'(k), 2'd0});
            end
            ack(k == 6);
            if (k < 6) begin
                n_cmp++;
                if ({chk_req, top, lock_pulse} !== {1'b0, 5'(k), 1'b0}) begin
                    n_bad++; $display("FAIL hard_drop_gap%0d: got req=%b top=%0d lock=%b want 0/%0d/0",
                                      k, chk_req, top, lock_pulse, k);
                end
                step();
            end
        end
        n_cmp++;
        if ({lock_pulse, top, alive} !== {1'b1, 5'd5, 1'b0}) begin
            n_bad++; $display("FAIL hard_drop_lock: got lock=%b top=%0d alive=%b want 1/5/0", lock_pulse, top, alive);
        end
        step(); step(); ack(0);
    endtask
`else
    task automatic test_drop();
        key_drop = 1; step(); key_drop = 0;
        n_cmp++;
        if (cand_bus() !== {1'b1, 3'd5, 5'd3, 5'd1, 2'd0}) begin
            n_bad++; $display("FAIL soft_drop_cand: got %h want %h", cand_bus(), {1'b1, 3'd5, 5'd3, 5'd1, 2'd0});
        end
        ack(0);
        step();
        n_cmp++;
        if ({chk_req, top} !== {1'b0, 5'd1}) begin
            n_bad++; $display("FAIL soft_drop_single: got req=%b top=%0d want 0/1", chk_req, top);
        end
        key_rot = 1; tick = 1; step(); key_rot = 0; tick = 0;
        ack(0);
        key_drop = 1; step(); key_drop = 0;
        n_cmp++;
        if (cand_bus() !== {1'b1, 3'd5, 5'd3, 5'd2, 2'd1}) begin
            n_bad++; $display("FAIL soft_drop_pending: got %h want %h", cand_bus(), {1'b1, 3'd5, 5'd3, 5'd2, 2'd1});
        end
        ack(0);
        step();
        n_cmp++;
        if (cand_bus() !== {1'b1, 3'd5, 5'd3, 5'd3, 2'd1}) begin
            n_bad++; $display("FAIL soft_drop_keeps_tick: got %h want %h", cand_bus(), {1'b1, 3'd5, 5'd3, 5'd3, 2'd1});
        end
        ack(0);
    endtask
`endif

    // Transaction-level model: the bench plays the checker and predicts each candidate from the rules.
    task automatic test_random(input int iters);
        piece_t cur, cand;
        bit     pend, have_check, go, hit, kd, kro, kl, kr, tk;
        int     mv;
        logic [2:0] r;

        Reset = 1; clear_inputs(); step(); Reset = 0;
        cur = '0; pend = 0;
        r = 3'($urandom % 8);
        rnd = r; start = 1; step(); start = 0; step();
        cand = {shape_of(r), 5'd3, 5'd0, 2'd0};
        mv = C_SPAWN; have_check = 1;
        n_cmp++;
        if (cand_bus() !== {1'b1, cand}) begin
            n_bad++; $display("FAIL rnd_first_spawn: got %h want %h", cand_bus(), {1'b1, cand});
        end

        for (int it = 0; it < iters; it++) begin
            if (!have_check) begin
                kd = ($urandom % 8) == 0; kro = ($urandom % 4) == 0;
                kl = ($urandom % 3) == 0; kr = ($urandom % 3) == 0; tk = ($urandom % 3) == 0;
                key_drop = kd; key_rot = kro; key_left = kl; key_right = kr; tick = tk;
                step(); clear_inputs();
                pend = pend | tk;
                cand = cur; go = 1; mv = C_SIDE;
                if (kd) begin
                    cand.top = cur.top + 5'd1;
`ifdef PIECE_HARD_DROP_EN
                    mv = C_HDROP;
`else
                    mv = C_GRAV;
`endif
                end else if (kro) begin
                    cand.rot = cur.rot + 2'd1; mv = C_ROT;
                end else if (kl) begin
                    if (cur.left == 5'd0) go = 0;
                    else cand.left = cur.left - 5'd1;
                end else if (kr) begin
                    cand.left = cur.left + 5'd1;
                end else if (pend) begin
                    cand.top = cur.top + 5'd1; mv = C_GRAV; pend = 0;
                end else begin
                    go = 0;
                end
                n_cmp++;
                if (go) begin
                    have_check = 1;
                    if (cand_bus() !== {1'b1, cand}) begin
                        n_bad++; $display("FAIL rnd_cmd_%0d: got %h want %h", it, cand_bus(), {1'b1, cand});
                    end
                end else if ({chk_req, committed_bus()} !== {1'b0, 1'b1, cur}) begin
                    n_bad++; $display("FAIL rnd_idle_%0d: got req=%b %h want req=0 %h", it, chk_req, committed_bus(), {1'b1, cur});
                end
            end else begin
                if (mv == C_SPAWN) hit = ($urandom % 6) == 0;
                else if (cand.left > 5'd6 || cand.top > 5'd19) hit = 1;
                else hit = ($urandom % 4) == 0;
                for (int w = $urandom % 3; w > 0; w--) begin
                    tk = ($urandom % 3) == 0;
                    tick = tk; key_left = 1'($urandom); key_rot = 1'($urandom); key_drop = 1'($urandom);
                    step(); clear_inputs();
                    pend = pend | tk;
                    n_cmp++;
                    if (cand_bus() !== {1'b1, cand}) begin
                        n_bad++; $display("FAIL rnd_hold_%0d: got %h want %h", it, cand_bus(), {1'b1, cand});
                    end
                end
                r = 3'($urandom % 8);
                rnd = r;
                ack(hit);
                n_cmp++;
                if (!hit) begin
                    cur = cand;
                    if (committed_bus() !== {1'b1, cur} || chk_req !== 1'b0) begin
                        n_bad++; $display("FAIL rnd_commit_%0d: got req=%b %h want req=0 %h", it, chk_req, committed_bus(), {1'b1, cur});
                    end
                    if (mv == C_HDROP) begin
                        step();
                        cand.top = cur.top + 5'd1;
                    end else begin
                        have_check = 0;
                    end
                end else if (mv == C_SPAWN) begin
                    if ({game_over, alive} !== 2'b10) begin
                        n_bad++; $display("FAIL rnd_over_%0d: got over=%b alive=%b want 1/0", it, game_over, alive);
                    end
                    start = 1; step(); start = 0; step();
                    cand = {shape_of(r), 5'd3, 5'd0, 2'd0};
                    n_cmp++;
                    if (cand_bus() !== {1'b1, cand}) begin
                        n_bad++; $display("FAIL rnd_restart_%0d: got %h want %h", it, cand_bus(), {1'b1, cand});
                    end
                end else if (mv == C_GRAV || mv == C_HDROP) begin
                    if ({lock_pulse, alive} !== 2'b10) begin
                        n_bad++; $display("FAIL rnd_lock_%0d: got lock=%b alive=%b want 1/0", it, lock_pulse, alive);
                    end
                    step(); step();
                    cand = {shape_of(r), 5'd3, 5'd0, 2'd0};
                    mv = C_SPAWN;
                    n_cmp++;
                    if (cand_bus() !== {1'b1, cand}) begin
                        n_bad++; $display("FAIL rnd_spawn_%0d: got %h want %h", it, cand_bus(), {1'b1, cand});
                    end
                end else begin
                    have_check = 0;
                    if ({chk_req, committed_bus()} !== {1'b0, 1'b1, cur}) begin
                        n_bad++; $display("FAIL rnd_discard_%0d: got req=%b %h want req=0 %h", it, chk_req, committed_bus(), {1'b1, cur});
                    end
                end
            end
        end
    endtask

    initial begin
        Reset = 1;
        clear_inputs();
        rnd = 3'd0;
        test_reset();
        test_spawn();
        test_left_edge();
        test_rot_tick();
        test_lock();
        test_game_over();
        test_drop();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
